// File: rtl/pkg_jogo_memoria.sv
// Shared definitions for the display sequencer: state codes, default timing
// constants and the helper that turns a duration into a timer load value.
package pkg_jogo_memoria;

  localparam int unsigned T_ACESO_PADRAO   = 500;
  localparam int unsigned T_APAGADO_PADRAO = 250;
  localparam int unsigned LARGURA_TIMER    = 10;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  // A phase lasting D cycles loads D-1 so the zero flag marks its last cycle.
  // Fast mode halves the duration; the result never drops below one cycle.
  function automatic logic [LARGURA_TIMER-1:0] carga_timer(input int unsigned duracao,
                                                           input logic rapido);
    int unsigned efetiva;
    efetiva = rapido ? (duracao >> 1) : duracao;
    if (efetiva == 0) efetiva = 1;
    return LARGURA_TIMER'(efetiva - 1);
  endfunction

endpackage

// File: rtl/contador_decrescente.sv
// Loadable down-counter with enable and a zero flag; stops at zero.
module contador_decrescente
  import pkg_jogo_memoria::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     carga,
  input  logic                     habilita,
  input  logic [LARGURA_TIMER-1:0] valor,
  output logic                     zero
);

  logic [LARGURA_TIMER-1:0] contagem;

  // Load has priority over counting; counting saturates at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (carga) begin
      contagem <= valor;
    end else if (habilita && (contagem != '0)) begin
      contagem <= contagem - 1'b1;
    end
  end

  assign zero = (contagem == '0);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Reads a run of nibbles from an external RAM and shows each one on a
// one-hot LED bank for a fixed on-time followed by a fixed dark gap.
module sequenciador_exibicao
  import pkg_jogo_memoria::*;
#(
  parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
  parameter int unsigned T_APAGADO = T_APAGADO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] limite,
  input  logic [1:0] modo,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  estado_t                  estado, proximo;
  logic [3:0]               limite_q;
  logic                     rapido_q;
  logic                     timer_zero;
  logic                     timer_carga;
  logic                     timer_habilita;
  logic [LARGURA_TIMER-1:0] timer_valor;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the pre-edge values of the others.
      estado <= proximo;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    // NOTE: default first so no path leaves proximo unassigned (no latch).
    proximo = estado;
    if (abortar) begin
      proximo = OCIOSO;
    end else begin
      case (estado)
        OCIOSO:  if (iniciar) proximo = CARREGA;
        CARREGA: proximo = ACESO;
        ACESO:   if (timer_zero) proximo = APAGADO;
        APAGADO: if (timer_zero) proximo = (mem_endereco == limite_q) ? FIM : CARREGA;
        FIM:     proximo = OCIOSO;
        default: proximo = OCIOSO;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    ocupado   = (estado != OCIOSO);
    pronto    = (estado == FIM);
    db_estado = 3'(estado);
  end

  // Timer control: load entering ACESO and entering APAGADO, count otherwise.
  always_comb begin
    timer_carga    = (estado == CARREGA) || ((estado == ACESO) && timer_zero);
    timer_habilita = ((estado == ACESO) || (estado == APAGADO)) && !timer_zero;
    timer_valor    = (estado == CARREGA) ? carga_timer(T_ACESO, rapido_q)
                                         : carga_timer(T_APAGADO, rapido_q);
  end

  contador_decrescente u_timer (
    .clock    (clock),
    .reset    (reset),
    .carga    (timer_carga),
    .habilita (timer_habilita),
    .valor    (timer_valor),
    .zero     (timer_zero)
  );

  // Datapath: latched settings, RAM address and LED register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limite_q     <= '0;
      rapido_q     <= 1'b0;
      mem_endereco <= '0;
      leds         <= '0;
    end else if (abortar) begin
      mem_endereco <= '0;
      leds         <= '0;
    end else begin
      if ((estado == OCIOSO) && iniciar) begin
        limite_q     <= limite;
        rapido_q     <= modo[0];
        mem_endereco <= modo[1] ? limite : 4'd0;
      end else if ((estado == APAGADO) && timer_zero && (mem_endereco != limite_q)) begin
        mem_endereco <= mem_endereco + 4'd1;
      end

      // LEDs hold the captured nibble through ACESO and are dark elsewhere.
      if (estado == CARREGA) begin
        leds <= mem_dado;
      end else if ((estado == ACESO) && !timer_zero) begin
        leds <= leds;
      end else begin
        leds <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Directed bench for sequenciador_exibicao: a table of whole-sequence vectors
// plus hand-written sequences for per-cycle timing, abort and reset.
module tb_sequenciador_exibicao;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, abortar = 1'b0;
  logic [3:0] limite = '0;
  logic [1:0] modo = '0;
  logic [3:0] mem_dado, mem_endereco, leds;
  logic       ocupado, pronto;
  logic [2:0] db_estado;

  logic       iniciar_b = 1'b0;
  logic [3:0] limite_b = '0;
  logic [1:0] modo_b = '0;
  logic [3:0] mem_dado_b, mem_endereco_b, leds_b;
  logic       ocupado_b, pronto_b;
  logic [2:0] db_estado_b;

  logic [3:0] ram [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  assign mem_dado   = ram[mem_endereco];
  assign mem_dado_b = ram[mem_endereco_b];

  sequenciador_exibicao #(.T_ACESO(4), .T_APAGADO(2)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .limite(limite), .modo(modo), .mem_dado(mem_dado),
    .mem_endereco(mem_endereco), .leds(leds), .ocupado(ocupado),
    .pronto(pronto), .db_estado(db_estado)
  );

  sequenciador_exibicao #(.T_ACESO(2), .T_APAGADO(2)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar_b), .abortar(1'b0),
    .limite(limite_b), .modo(modo_b), .mem_dado(mem_dado_b),
    .mem_endereco(mem_endereco_b), .leds(leds_b), .ocupado(ocupado_b),
    .pronto(pronto_b), .db_estado(db_estado_b)
  );

  task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    n_tests++;
    if (obtido !== esperado) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, obtido, esperado);
    end
  endtask

  // Presents a start request so the next rising edge is edge 0.
  task automatic pulse_start(input logic [3:0] lim, input logic [1:0] md);
    @(negedge clock);
    limite  = lim;
    modo    = md;
    iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
  endtask

  typedef struct {
    logic [3:0] lim;
    logic [1:0] md;
    int         ciclo_pronto;
    logic [3:0] leds_ciclo2;
    logic [3:0] end_final;
  } vetor_t;

  vetor_t vetores [7];

  initial begin
    int ciclo_p, qtd_p, erros_end, erros_led;
    logic [3:0] leds2, end_p;
    logic ocup_depois;
    logic [12:0] esperado, obtido;

    // Bench RAM image: addresses 0..3 walk a one-hot bit; address 5 is 1000.
    for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));
    ram[5] = 4'b1000;

    //              lim    modo   pronto  leds@2   addr
    vetores[0] = '{4'd2, 2'b00, 22, 4'b0001, 4'd2};
    vetores[1] = '{4'd1, 2'b01,  9, 4'b0001, 4'd1};
    vetores[2] = '{4'd5, 2'b10,  8, 4'b1000, 4'd5};
    vetores[3] = '{4'd0, 2'b00,  8, 4'b0001, 4'd0};
    vetores[4] = '{4'd0, 2'b11,  5, 4'b0001, 4'd0};
    vetores[5] = '{4'd3, 2'b11,  5, 4'b1000, 4'd3};
    vetores[6] = '{4'd3, 2'b01, 17, 4'b0001, 4'd3};

    // Reset state, checked before any clock edge.
    #2 reset = 1'b0;
    #1 check("reset_outputs", {db_estado, leds, mem_endereco, ocupado, pronto}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Whole-sequence vectors; inputs are scrambled while busy to show they are latched.
    for (int i = 0; i < 7; i++) begin
      pulse_start(vetores[i].lim, vetores[i].md);
      limite = ~vetores[i].lim;
      modo   = ~vetores[i].md;
      ciclo_p = 0; qtd_p = 0; leds2 = '0; end_p = '0; ocup_depois = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clock);
        if (c == 2) leds2 = leds;
        if (ciclo_p != 0 && c == ciclo_p + 1) ocup_depois = ocupado;
        if (pronto) begin
          qtd_p++;
          if (ciclo_p == 0) begin ciclo_p = c; end_p = mem_endereco; end
        end
      end
      check($sformatf("vec%0d_pronto_cycle", i), ciclo_p, vetores[i].ciclo_pronto);
      check($sformatf("vec%0d_pronto_count", i), qtd_p, 1);
      check($sformatf("vec%0d_leds_c2", i), leds2, vetores[i].leds_ciclo2);
      check($sformatf("vec%0d_final_addr", i), end_p, vetores[i].end_final);
      check($sformatf("vec%0d_idle_after", i), ocup_depois, 0);
    end

    // Per-cycle trace of the normal three-entry sequence.
    pulse_start(4'd2, 2'b00);
    for (int c = 1; c <= 23; c++) begin
      int e, ph;
      @(negedge clock);
      e  = (c - 1) / 7;
      ph = (c - 1) % 7;
      if (c == 23)      esperado = {3'd0, 4'b0000, 4'd2, 1'b0, 1'b0};
      else if (c == 22) esperado = {3'd4, 4'b0000, 4'd2, 1'b1, 1'b1};
      else if (ph == 0) esperado = {3'd1, 4'b0000, 4'(e), 1'b1, 1'b0};
      else if (ph <= 4) esperado = {3'd2, 4'(1 << e), 4'(e), 1'b1, 1'b0};
      else              esperado = {3'd3, 4'b0000, 4'(e), 1'b1, 1'b0};
      obtido = {db_estado, leds, mem_endereco, ocupado, pronto};
      check($sformatf("trace_cycle%0d", c), obtido, esperado);
    end

    // Abort during ACESO of the second entry, then a clean restart.
    pulse_start(4'd2, 2'b00);
    repeat (10) @(negedge clock);
    check("abort_pre_state", {db_estado, mem_endereco}, {3'd2, 4'd1});
    abortar = 1'b1;
    @(negedge clock);
    check("abort_outputs", {db_estado, leds, mem_endereco, ocupado, pronto}, 32'd0);
    abortar = 1'b0;
    qtd_p = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (pronto || ocupado) qtd_p++;
    end
    check("abort_stays_idle", qtd_p, 0);
    pulse_start(4'd2, 2'b00);
    @(negedge clock);
    check("restart_addr0", {db_estado, mem_endereco}, {3'd1, 4'd0});
    ciclo_p = 0;
    for (int c = 2; c <= 30; c++) begin
      @(negedge clock);
      if (pronto && ciclo_p == 0) ciclo_p = c;
    end
    check("restart_pronto_cycle", ciclo_p, 22);

    // Busy-time iniciar, then asynchronous reset in APAGADO.
    pulse_start(4'd2, 2'b00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (c == 4) iniciar = 1'b1;
      if (c == 5) iniciar = 1'b0;
    end
    check("busy_start_no_effect", {db_estado, mem_endereco}, {3'd3, 4'd0});
    #1 reset = 1'b0;
    #1 check("async_reset_outputs", {db_estado, leds, mem_endereco, ocupado, pronto}, 32'd0);
    qtd_p = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (pronto || ocupado || leds != 0) qtd_p++;
    end
    check("reset_hold_quiet", qtd_p, 0);
    reset = 1'b1;

    pulse_start(4'd1, 2'b00);
    ciclo_p = 0; qtd_p = 0; ocup_depois = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      if (ciclo_p != 0 && c == ciclo_p + 1) ocup_depois = ocupado;
      if (pronto) begin qtd_p++; if (ciclo_p == 0) ciclo_p = c; end
      iniciar = (c == 3 || c == 9);
    end
    iniciar = 1'b0;
    check("busy_iniciar_pronto_cycle", ciclo_p, 15);
    check("busy_iniciar_pronto_count", qtd_p, 1);
    check("busy_iniciar_no_restart", ocup_depois, 0);

    // Sixteen entries at minimum timing on the second instance.
    @(negedge clock);
    limite_b = 4'd15; modo_b = 2'b01; iniciar_b = 1'b1;
    @(posedge clock);
    #1 iniciar_b = 1'b0;
    ciclo_p = 0; qtd_p = 0; erros_end = 0; erros_led = 0; end_p = '0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clock);
      if (c <= 49 && mem_endereco_b != ((c == 49) ? 4'd15 : 4'((c - 1) / 3))) erros_end++;
      if (c < 49 && (c - 1) % 3 == 1 && leds_b != ram[(c - 1) / 3]) erros_led++;
      if (pronto_b) begin
        qtd_p++;
        if (ciclo_p == 0) begin ciclo_p = c; end_p = mem_endereco_b; end
      end
    end
    check("long_addr_sequence_errors", erros_end, 0);
    check("long_leds_errors", erros_led, 0);
    check("long_pronto_cycle", ciclo_p, 49);
    check("long_pronto_count", qtd_p, 1);
    check("long_final_addr", end_p, 15);
    check("long_idle_after", {ocupado_b, db_estado_b}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
